bs_drvr_intrfc: RTL and testbench
=================================

Name: bs_drvr_intrfc

Overview:
- Device-side endpoint for one port of the parameterised bus/arbiter system (bs_gnrtr_n_rbtr).
- It is the other end of the pndng/pop/D_pop and push/D_push handshake: it presents queued outgoing packets to the bus and absorbs packets the bus delivers.
- Contains a TX FIFO that drives pndng/D_pop and advances on pop.
- Contains an RX FIFO that captures push/D_push packets addressed to this port's ID or to broadcast.
- Packet format: [PCKG_SZ-1:PCKG_SZ-8] target, [PCKG_SZ-9:PCKG_SZ-16] source, [PCKG_SZ-17:0] payload/ID.

Parameters:
- PCKG_SZ, 32, packet width in bits (>=17).
- DEPTH, 8, entries per FIFO (power of two, >=2).
- ID, 0, 8-bit address of this port.
- BROADCAST, 8'hFF, target value accepted by every port.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- tx_wr  in  1  device writes tx_data into TX FIFO.
- tx_data  in  PCKG_SZ  packet to send.
- tx_full  out  1  TX FIFO holds DEPTH entries.
- pndng  out  1  TX FIFO non-empty; request to bus.
- D_pop  out  PCKG_SZ  TX FIFO head (show-ahead).
- pop  in  1  bus consumed D_pop this cycle.
- push  in  1  bus delivers D_push this cycle.
- D_push  in  PCKG_SZ  delivered packet.
- rx_rd  in  1  device consumes rx_data.
- rx_data  out  PCKG_SZ  RX FIFO head (show-ahead).
- rx_empty  out  1  RX FIFO empty.
- rx_cnt  out  $clog2(DEPTH)+1  RX occupancy.
- drop_cnt  out  16  saturating count of addressed packets lost because RX was full.
- pop_err  out  1  sticky: pop seen while pndng=0.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Both FIFOs empty; pointers = 0.
  - pndng=0, tx_full=0, D_pop=0, rx_empty=1, rx_cnt=0, rx_data=0, drop_cnt=0, pop_err=0.
  - Reset mid-operation discards all queued packets in both FIFOs.
- TX FIFO:
  - tx_wr at edge n: entry written; pndng=1 from n+1.
  - D_pop always shows the head; it is stable while pndng=1 and no pop occurs.
  - pop with pndng=1 advances the head at that edge; the next head appears on D_pop from the following cycle.
  - pop with pndng=0 is ignored; pop_err is set until reset.
  - tx_wr with tx_full=1 and no pop: write dropped, state unchanged.
  - tx_wr with tx_full=1 and pop in the same cycle: both take effect; count stays DEPTH.
  - Simultaneous tx_wr and pop when count=1: the new entry becomes head; pndng stays 1.
  - Pointers wrap modulo DEPTH; occupancy counter width is $clog2(DEPTH)+1.
- RX accept rule:
  - Accept when push=1 and target==ID or target==BROADCAST.
  - Any other push is silently discarded and does not count toward drop_cnt.
- RX FIFO:
  - Accepted push at edge n: rx_empty=0 and rx_cnt incremented from n+1.
  - Accepted push when full and rx_rd=0: packet lost; drop_cnt increments, saturating at 16'hFFFF.
  - Accepted push when full and rx_rd=1 in the same cycle: both take effect; no drop.
  - rx_rd with rx_empty=1 is ignored.
- No combinational path from pop to pndng/D_pop, or from push to rx_empty/rx_data; all outputs are registered or decoded from FIFO state.

Optional Feature:
- Macro: BS_LOOPBACK_FILTER_EN.
- Defined: a broadcast packet whose source field equals ID is discarded on RX (own echo suppression). It is not stored and not counted in drop_cnt. Unicast packets to ID are unaffected.
- Undefined: broadcast packets are accepted regardless of source.

Test Plan:
- Reset, then tx_wr with 0x0100_0005 (ID=0) -> next cycle pndng=1, D_pop=0x0100_0005; pop -> following cycle pndng=0, pop_err=0.
- Write 8 packets with DEPTH=8, then a 9th with no pop -> tx_full=1, 9th dropped. Pop 8 times -> the original 8 are seen in order, then pndng=0.
- push D_push=0x0001_0003 (ID=0) -> rx_empty=0, rx_data=0x0001_0003, rx_cnt=1. push 0x0201_0004 -> ignored, rx_cnt stays 1, drop_cnt=0.
- Fill RX to 8, then push 0xFF01_0009 with rx_rd=0 -> drop_cnt=1. Repeat with rx_rd=1 -> accepted, drop_cnt stays 1, rx_cnt=8.
- push 0xFF00_0007 (source=ID=0): with BS_LOOPBACK_FILTER_EN -> rx_cnt unchanged; without it -> stored.
- Assert reset asynchronously mid-cycle with both FIFOs partially full -> immediately pndng=0, rx_empty=1, drop_cnt=0. pop while empty -> pop_err=1.

Source files
------------

// File: rtl/bs_drvr_intrfc.sv
// Device-side endpoint for one port of the bus/arbiter system.
// A TX FIFO holds outgoing packets. It shows its head on D_pop and raises
// pndng while it is non-empty. The bus takes the head by pulsing pop.
// An RX FIFO stores packets that the bus delivers with push/D_push when the
// target field matches ID or BROADCAST. The device reads them through
// rx_rd/rx_data.
// Optional build macro BS_LOOPBACK_FILTER_EN: when defined, the RX side
// discards any broadcast packet whose source field equals ID, so a port does
// not receive its own broadcasts.
// Packet layout: [PCKG_SZ-1 -: 8] target, [PCKG_SZ-9 -: 8] source, rest payload.
module bs_drvr_intrfc #(
  parameter int unsigned PCKG_SZ   = 32,
  parameter int unsigned DEPTH     = 8,
  parameter logic [7:0]  ID        = 8'h00,
  parameter logic [7:0]  BROADCAST = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  // Device-side TX write port
  input  logic                     tx_wr,
  input  logic [PCKG_SZ-1:0]       tx_data,
  output logic                     tx_full,
  // Bus-side TX handshake
  output logic                     pndng,
  output logic [PCKG_SZ-1:0]       D_pop,
  input  logic                     pop,
  // Bus-side RX delivery
  input  logic                     push,
  input  logic [PCKG_SZ-1:0]       D_push,
  // Device-side RX read port
  input  logic                     rx_rd,
  output logic [PCKG_SZ-1:0]       rx_data,
  output logic                     rx_empty,
  output logic [$clog2(DEPTH):0]   rx_cnt,
  output logic [15:0]              drop_cnt,
  output logic                     pop_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [PCKG_SZ-1:0] tx_mem_q [DEPTH];
  logic [AW-1:0]      tx_wptr_q, tx_wptr_d;
  logic [AW-1:0]      tx_rptr_q, tx_rptr_d;
  logic [CW-1:0]      tx_cnt_q,  tx_cnt_d;
  logic               pop_err_q, pop_err_d;
  logic               tx_empty;
  logic               tx_pop_ok;
  logic               tx_wr_ok;

  // TX next-state: a pop frees the head slot in the same edge, so a write to a
  // full FIFO is accepted when it coincides with a valid pop.
  always_comb begin
    tx_empty  = (tx_cnt_q == '0);
    tx_full   = (tx_cnt_q == FullCnt);
    tx_pop_ok = pop & ~tx_empty;
    tx_wr_ok  = tx_wr & (~tx_full | tx_pop_ok);
    tx_wptr_d = tx_wptr_q + AW'(tx_wr_ok);
    tx_rptr_d = tx_rptr_q + AW'(tx_pop_ok);
    tx_cnt_d  = tx_cnt_q;
    case ({tx_wr_ok, tx_pop_ok})
      2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
    pop_err_d = pop_err_q | (pop & tx_empty);
  end

  // TX pointer, occupancy and sticky error state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      pop_err_q <= 1'b0;
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      pop_err_q <= pop_err_d;
    end
  end

  // TX storage; the contents need no reset because the outputs are masked when empty
  always_ff @(posedge clk) begin
    if (tx_wr_ok) begin
      tx_mem_q[tx_wptr_q] <= tx_data;
    end
  end

  // TX outputs decoded from FIFO state only, never from pop
  always_comb begin
    pndng   = ~tx_empty;
    D_pop   = tx_empty ? '0 : tx_mem_q[tx_rptr_q];
    pop_err = pop_err_q;
  end

  // ---------------------------------------------------------------------------
  // RX address filter
  // ---------------------------------------------------------------------------
  logic [7:0] rx_tgt;
  logic       rx_hit;
  logic       rx_echo;
  logic       rx_acc;

`ifdef BS_LOOPBACK_FILTER_EN
  logic [7:0] rx_src;

  // Accept unicast-to-ID and broadcast, but drop our own broadcast echoes
  always_comb begin
    rx_tgt  = D_push[PCKG_SZ-1 -: 8];
    rx_src  = D_push[PCKG_SZ-9 -: 8];
    rx_hit  = push & ((rx_tgt == ID) | (rx_tgt == BROADCAST));
    rx_echo = (rx_tgt == BROADCAST) & (rx_src == ID);
    rx_acc  = rx_hit & ~rx_echo;
  end
`else
  // Accept unicast-to-ID and every broadcast
  always_comb begin
    rx_tgt  = D_push[PCKG_SZ-1 -: 8];
    rx_hit  = push & ((rx_tgt == ID) | (rx_tgt == BROADCAST));
    rx_echo = 1'b0;
    rx_acc  = rx_hit & ~rx_echo;
  end
`endif

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [PCKG_SZ-1:0] rx_mem_q [DEPTH];
  logic [AW-1:0]      rx_wptr_q, rx_wptr_d;
  logic [AW-1:0]      rx_rptr_q, rx_rptr_d;
  logic [CW-1:0]      rx_cnt_q,  rx_cnt_d;
  logic [15:0]        drop_q,    drop_d;
  logic               rx_full;
  logic               rx_rd_ok;
  logic               rx_wr_ok;
  logic               rx_drop;

  // RX next-state: a read in the same cycle makes room for an accepted push;
  // only accepted packets that still find no room count as drops.
  always_comb begin
    rx_empty  = (rx_cnt_q == '0);
    rx_full   = (rx_cnt_q == FullCnt);
    rx_rd_ok  = rx_rd & ~rx_empty;
    rx_wr_ok  = rx_acc & (~rx_full | rx_rd_ok);
    rx_drop   = rx_acc & ~rx_wr_ok;
    rx_wptr_d = rx_wptr_q + AW'(rx_wr_ok);
    rx_rptr_d = rx_rptr_q + AW'(rx_rd_ok);
    rx_cnt_d  = rx_cnt_q;
    case ({rx_wr_ok, rx_rd_ok})
      2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
    drop_d = drop_q;
    if (rx_drop && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  // RX pointer, occupancy and drop counter state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      drop_q    <= '0;
    end else begin
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
      drop_q    <= drop_d;
    end
  end

  // RX storage; the contents need no reset because rx_data is masked when empty
  always_ff @(posedge clk) begin
    if (rx_wr_ok) begin
      rx_mem_q[rx_wptr_q] <= D_push;
    end
  end

  // RX outputs decoded from FIFO state only, never from push
  always_comb begin
    rx_data  = rx_empty ? '0 : rx_mem_q[rx_rptr_q];
    rx_cnt   = rx_cnt_q;
    drop_cnt = drop_q;
  end

endmodule

// File: tb/tb_bs_drvr_intrfc.sv
// Self-checking bench for bs_drvr_intrfc. It runs directed steps from the
// test plan and then randomized traffic. A queue-based model of both FIFOs
// supplies every expected value.
module tb_bs_drvr_intrfc;

  localparam int unsigned PCKG_SZ   = 32;
  localparam int unsigned DEPTH     = 8;
  localparam logic [7:0]  ID        = 8'h00;
  localparam logic [7:0]  BROADCAST = 8'hFF;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   tx_wr;
  logic [PCKG_SZ-1:0]     tx_data;
  logic                   tx_full;
  logic                   pndng;
  logic [PCKG_SZ-1:0]     D_pop;
  logic                   pop;
  logic                   push;
  logic [PCKG_SZ-1:0]     D_push;
  logic                   rx_rd;
  logic [PCKG_SZ-1:0]     rx_data;
  logic                   rx_empty;
  logic [$clog2(DEPTH):0] rx_cnt;
  logic [15:0]            drop_cnt;
  logic                   pop_err;

  bs_drvr_intrfc #(
    .PCKG_SZ  (PCKG_SZ),
    .DEPTH    (DEPTH),
    .ID       (ID),
    .BROADCAST(BROADCAST)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_wr   (tx_wr),
    .tx_data (tx_data),
    .tx_full (tx_full),
    .pndng   (pndng),
    .D_pop   (D_pop),
    .pop     (pop),
    .push    (push),
    .D_push  (D_push),
    .rx_rd   (rx_rd),
    .rx_data (rx_data),
    .rx_empty(rx_empty),
    .rx_cnt  (rx_cnt),
    .drop_cnt(drop_cnt),
    .pop_err (pop_err)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [PCKG_SZ-1:0] tx_q[$];
  logic [PCKG_SZ-1:0] rx_q[$];
  int unsigned        m_drop;
  bit                 m_pop_err;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    tx_q.delete();
    rx_q.delete();
    m_drop    = 0;
    m_pop_err = 0;
  endtask

  // One clock edge of the spec's rules applied to the queues
  task automatic model_update();
    bit         pop_ok, wr_ok, rd_ok, addressed;
    logic [7:0] tgt, src;
    pop_ok = pop && (tx_q.size() != 0);
    wr_ok  = tx_wr && ((tx_q.size() < DEPTH) || pop_ok);
    if (pop && (tx_q.size() == 0)) m_pop_err = 1;
    if (pop_ok) tx_q.delete(0);
    if (wr_ok) tx_q.push_back(tx_data);
    tgt       = D_push[31:24];
    src       = D_push[23:16];
    addressed = push && ((tgt == ID) || (tgt == BROADCAST));
`ifdef BS_LOOPBACK_FILTER_EN
    if ((tgt == BROADCAST) && (src == ID)) addressed = 0;
`else
    if (src == 8'h5A) addressed = addressed; // source ignored without the filter
`endif
    rd_ok = rx_rd && (rx_q.size() != 0);
    if (rd_ok) rx_q.delete(0);
    if (addressed) begin
      if (rx_q.size() < DEPTH) rx_q.push_back(D_push);
      else if (m_drop < 32'hFFFF) m_drop++;
    end
  endtask

  task automatic check_all();
    chk("pndng",    {31'd0, pndng},    {31'd0, tx_q.size() != 0});
    chk("tx_full",  {31'd0, tx_full},  {31'd0, tx_q.size() == DEPTH});
    chk("D_pop",    D_pop,             (tx_q.size() != 0) ? tx_q[0] : 32'd0);
    chk("rx_empty", {31'd0, rx_empty}, {31'd0, rx_q.size() == 0});
    chk("rx_data",  rx_data,           (rx_q.size() != 0) ? rx_q[0] : 32'd0);
    chk("rx_cnt",   {28'd0, rx_cnt},   rx_q.size());
    chk("drop_cnt", {16'd0, drop_cnt}, m_drop);
    chk("pop_err",  {31'd0, pop_err},  {31'd0, m_pop_err});
  endtask

  // Apply the current inputs for one rising edge, then check at the next falling edge
  task automatic step();
    @(posedge clk);
    if (!reset) model_update();
    @(negedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    tx_wr   = 0;
    tx_data = '0;
    pop     = 0;
    push    = 0;
    D_push  = '0;
    rx_rd   = 0;
  endtask

  int unsigned wr_pct, pop_pct, push_pct, rd_pct;
  logic [7:0]  r_tgt, r_src;

  initial begin
    idle_inputs();
    reset = 1;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    check_all();
    chk("rst_rx_empty", {31'd0, rx_empty}, 32'd1);
    chk("rst_pndng",    {31'd0, pndng},    32'd0);

    // Single TX packet round trip
    tx_wr = 1; tx_data = 32'h0100_0005;
    step();
    tx_wr = 0;
    chk("t1_pndng", {31'd0, pndng}, 32'd1);
    chk("t1_dpop",  D_pop, 32'h0100_0005);
    pop = 1;
    step();
    pop = 0;
    chk("t1_pndng_after", {31'd0, pndng}, 32'd0);
    chk("t1_pop_err",     {31'd0, pop_err}, 32'd0);

    // Fill TX, overflow with a 9th write, then drain in order
    for (int i = 0; i < 9; i++) begin
      tx_wr = 1; tx_data = 32'hA000_0000 + i;
      step();
    end
    tx_wr = 0;
    chk("tx_full_set", {31'd0, tx_full}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("tx_order", D_pop, 32'hA000_0000 + i);
      pop = 1;
      step();
    end
    pop = 0;
    chk("tx_drained", {31'd0, pndng}, 32'd0);

    // Addressed versus non-addressed RX pushes
    push = 1; D_push = 32'h0001_0003;
    step();
    chk("rx1_empty", {31'd0, rx_empty}, 32'd0);
    chk("rx1_data",  rx_data, 32'h0001_0003);
    chk("rx1_cnt",   {28'd0, rx_cnt}, 32'd1);
    D_push = 32'h0201_0004;
    step();
    chk("rx2_cnt",  {28'd0, rx_cnt}, 32'd1);
    chk("rx2_drop", {16'd0, drop_cnt}, 32'd0);

    // Fill RX, then overflow without and with a concurrent read
    for (int i = 0; i < 7; i++) begin
      D_push = 32'h0001_0100 + i;
      step();
    end
    chk("rx_fill_cnt", {28'd0, rx_cnt}, 32'd8);
    D_push = 32'hFF01_0009;
    step();
    chk("rx_drop1", {16'd0, drop_cnt}, 32'd1);
    rx_rd = 1;
    step();
    chk("rx_drop_hold", {16'd0, drop_cnt}, 32'd1);
    chk("rx_cnt_full",  {28'd0, rx_cnt}, 32'd8);
    push = 0;
    repeat (3) step();
    rx_rd = 0;
    chk("rx_cnt_drain", {28'd0, rx_cnt}, 32'd5);

    // Own-source broadcast
    push = 1; D_push = 32'hFF00_0007;
    step();
    push = 0;
`ifdef BS_LOOPBACK_FILTER_EN
    chk("loopback_cnt", {28'd0, rx_cnt}, 32'd5);
`else
    chk("loopback_cnt", {28'd0, rx_cnt}, 32'd6);
`endif

    // Randomized traffic with varying fill/drain pressure
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) begin
        wr_pct   = ((i / 100) % 2 == 0) ? 70 : 30;
        pop_pct  = ((i / 100) % 2 == 0) ? 30 : 70;
        push_pct = ((i / 100) % 2 == 0) ? 80 : 40;
        rd_pct   = ((i / 100) % 2 == 0) ? 15 : 75;
      end
      tx_wr   = ($urandom_range(0, 99) < wr_pct);
      tx_data = $urandom;
      pop     = ($urandom_range(0, 99) < pop_pct);
      push    = ($urandom_range(0, 99) < push_pct);
      case ($urandom_range(0, 3))
        0:       r_tgt = ID;
        1:       r_tgt = BROADCAST;
        default: r_tgt = 8'($urandom);
      endcase
      r_src  = ($urandom_range(0, 1) == 0) ? ID : 8'($urandom);
      D_push = {r_tgt, r_src, 16'($urandom)};
      rx_rd  = ($urandom_range(0, 99) < rd_pct);
      step();
    end

    // Asynchronous reset mid-cycle with both FIFOs partially filled
    idle_inputs();
    tx_wr = 1; tx_data = 32'h1234_5678;
    push = 1; D_push = 32'h00AA_0001;
    step();
    step();
    idle_inputs();
    chk("pre_rst_pndng", {31'd0, pndng}, 32'd1);
    @(posedge clk);
    model_update();
    #2;
    reset = 1;
    #1;
    model_clear();
    chk("arst_pndng",    {31'd0, pndng},    32'd0);
    chk("arst_rx_empty", {31'd0, rx_empty}, 32'd1);
    chk("arst_drop",     {16'd0, drop_cnt}, 32'd0);
    check_all();
    @(negedge clk);
    reset = 0;
    pop = 1;
    step();
    pop = 0;
    chk("pop_err_set", {31'd0, pop_err}, 32'd1);
    step();
    chk("pop_err_sticky", {31'd0, pop_err}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
